// File: rtl/wb_queue_align_if.sv
// Memory-stage to writeback handshake bundle for wb_queue_align.
// The master drives the *_in signals and the slave (the queue) drives the *_out signals.
interface wb_queue_align_if #(
  parameter int RNUM_W = 5
);
  logic              mem_valid_in;
  logic              wb_allowin_out;
  logic [31:0]       mem_PC_in;
  logic [RNUM_W-1:0] mem_wnum_in;
  logic [31:0]       mem_wbdata_in;
  logic [31:0]       mem_dm_data_in;
  logic [2:0]        mem_ld_type_in;
  logic [1:0]        mem_adrl_in;
  logic              wb_flush_in;
  logic              rf_ready_in;
  logic              wb_valid_out;
  logic [3:0]        wb_reg_we_out;
  logic [RNUM_W-1:0] wb_wnum_out;
  logic [31:0]       wb_wbdata_out;

  modport master (
    output mem_valid_in, mem_PC_in, mem_wnum_in, mem_wbdata_in, mem_dm_data_in,
           mem_ld_type_in, mem_adrl_in, wb_flush_in, rf_ready_in,
    input  wb_allowin_out, wb_valid_out, wb_reg_we_out, wb_wnum_out, wb_wbdata_out
  );

  modport slave (
    input  mem_valid_in, mem_PC_in, mem_wnum_in, mem_wbdata_in, mem_dm_data_in,
           mem_ld_type_in, mem_adrl_in, wb_flush_in, rf_ready_in,
    output wb_allowin_out, wb_valid_out, wb_reg_we_out, wb_wnum_out, wb_wbdata_out
  );
endinterface

// File: rtl/wb_queue_align.sv
// Writeback queue that aligns load data when an entry is accepted and commits entries in order.
// Optional commit trace on debug_* is enabled by defining WB_DEBUG_TRACE_EN.
module wb_queue_align #(
  parameter int DEPTH  = 2,
  parameter int RNUM_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  wb_queue_align_if.slave          bus,
  output logic [$clog2(DEPTH):0]   wb_count_out,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, LD_LWL, LD_LWR
  } ld_type_e;

  logic [3:0]        r_we   [DEPTH];
  logic [RNUM_W-1:0] r_wnum [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic        w_accept;
  logic        w_commit;
  logic        w_valid;
  ld_type_e    w_ld;
  logic [31:0] w_shr;
  logic [15:0] w_half;
  logic [31:0] w_data;
  logic [3:0]  w_we;

  assign w_valid  = (r_count != '0);
  assign w_commit = w_valid && bus.rf_ready_in && !bus.wb_flush_in;

  // A full queue still accepts when its head retires in the same cycle.
  assign bus.wb_allowin_out = !rst && !bus.wb_flush_in && ((r_count != FULL) || w_commit);
  assign w_accept           = bus.mem_valid_in && bus.wb_allowin_out;

  assign bus.wb_valid_out  = w_valid;
  assign bus.wb_reg_we_out = w_valid ? r_we[r_head] : 4'b0000;
  assign bus.wb_wnum_out   = r_wnum[r_head];
  assign bus.wb_wbdata_out = r_data[r_head];
  assign wb_count_out      = r_count;

  assign w_ld   = ld_type_e'(bus.mem_ld_type_in);
  assign w_shr  = bus.mem_dm_data_in >> {bus.mem_adrl_in, 3'b000};
  assign w_half = bus.mem_adrl_in[1] ? bus.mem_dm_data_in[31:16] : bus.mem_dm_data_in[15:0];

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_data = bus.mem_wbdata_in;
    w_we   = 4'b1111;
    unique case (w_ld)
      LD_LB:  w_data = {{24{w_shr[7]}}, w_shr[7:0]};
      LD_LBU: w_data = {24'h0, w_shr[7:0]};
      LD_LH:  w_data = {{16{w_half[15]}}, w_half};
      LD_LHU: w_data = {16'h0, w_half};
      LD_LW:  w_data = bus.mem_dm_data_in;
      LD_LWL: begin
        w_data = bus.mem_dm_data_in << {~bus.mem_adrl_in, 3'b000};
        w_we   = 4'b1111 << ~bus.mem_adrl_in;
      end
      LD_LWR: begin
        w_data = w_shr;
        w_we   = 4'b1111 >> bus.mem_adrl_in;
      end
      default: w_data = bus.mem_wbdata_in;
    endcase
    if (bus.mem_wnum_in == '0) w_we = 4'b0000;
  end

  // NOTE: queue storage has no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we[r_tail]   <= w_we;
      r_wnum[r_tail] <= bus.mem_wnum_in;
      r_data[r_tail] <= w_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.wb_flush_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      unique case ({w_accept, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] r_pc [DEPTH];

  always_ff @(posedge clk) begin
    if (w_accept) r_pc[r_tail] <= bus.mem_PC_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (w_commit) begin
      debug_wb_pc       <= r_pc[r_head];
      debug_wb_rf_wen   <= r_we[r_head];
      debug_wb_rf_wnum  <= 5'(r_wnum[r_head]);
      debug_wb_rf_wdata <= r_data[r_head];
    end else begin
      debug_wb_rf_wen   <= '0;
    end
  end
`else
  logic w_pc_unused;
  assign w_pc_unused       = ^bus.mem_PC_in;
  assign debug_wb_pc       = '0;
  assign debug_wb_rf_wen   = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_queue_align.sv
// Directed bench for wb_queue_align: alignment table, full/bypass behaviour, flush and reset.
// Debug expectations follow WB_DEBUG_TRACE_EN.
module tb_wb_queue_align;

  localparam bit TRACE =
`ifdef WB_DEBUG_TRACE_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_count_out;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_vec = 0;
  int n_bad = 0;

  wb_queue_align_if #(.RNUM_W(5)) bus ();

  wb_queue_align #(.DEPTH(2), .RNUM_W(5)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus               (bus.slave),
    .wb_count_out      (wb_count_out),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  adrl;
    logic [31:0] dm;
    logic [31:0] wbd;
    logic [31:0] exp_d;
    logic [3:0]  exp_we;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] wn,
                       input logic [2:0] ld, input logic [1:0] a,
                       input logic [31:0] dm, input logic [31:0] wbd);
    bus.mem_valid_in   = v;
    bus.mem_PC_in      = pc;
    bus.mem_wnum_in    = wn;
    bus.mem_ld_type_in = ld;
    bus.mem_adrl_in    = a;
    bus.mem_dm_data_in = dm;
    bus.mem_wbdata_in  = wbd;
  endtask

  initial begin
    vecs[0]  = '{3'd1, 2'd2, 32'h1280_3456, 32'h0, 32'hFFFF_FF80, 4'hF};
    vecs[1]  = '{3'd2, 2'd2, 32'h1280_3456, 32'h0, 32'h0000_0080, 4'hF};
    vecs[2]  = '{3'd1, 2'd0, 32'h0000_007F, 32'h0, 32'h0000_007F, 4'hF};
    vecs[3]  = '{3'd3, 2'd2, 32'h1280_3456, 32'h0, 32'h0000_1280, 4'hF};
    vecs[4]  = '{3'd3, 2'd0, 32'h0000_8001, 32'h0, 32'hFFFF_8001, 4'hF};
    vecs[5]  = '{3'd4, 2'd0, 32'h0000_8001, 32'h0, 32'h0000_8001, 4'hF};
    vecs[6]  = '{3'd5, 2'd1, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 4'hF};
    vecs[7]  = '{3'd0, 2'd3, 32'hDEAD_BEEF, 32'h1357_2468, 32'h1357_2468, 4'hF};
    vecs[8]  = '{3'd6, 2'd1, 32'hAABB_CCDD, 32'h0, 32'hCCDD_0000, 4'hC};
    vecs[9]  = '{3'd6, 2'd3, 32'hAABB_CCDD, 32'h0, 32'hAABB_CCDD, 4'hF};
    vecs[10] = '{3'd7, 2'd1, 32'hAABB_CCDD, 32'h0, 32'h00AA_BBCC, 4'h7};
    vecs[11] = '{3'd7, 2'd0, 32'hAABB_CCDD, 32'h0, 32'hAABB_CCDD, 4'hF};

    rst = 1'b1;
    bus.wb_flush_in = 1'b0;
    bus.rf_ready_in = 1'b0;
    drive(1'b1, 32'h0, 5'd1, 3'd0, 2'd0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    #1;
    check("rst_count", wb_count_out, 0);
    check("rst_valid", bus.wb_valid_out, 0);
    check("rst_we", bus.wb_reg_we_out, 0);
    check("rst_allowin", bus.wb_allowin_out, 1);
    check("rst_dbg_pc", debug_wb_pc, 0);
    check("rst_dbg_wen", debug_wb_rf_wen, 0);

    // Alignment table: each entry queued, inspected at the head, then committed.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 5'd3, vecs[i].ld, vecs[i].adrl, vecs[i].dm, vecs[i].wbd);
      tick();
      drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
      check($sformatf("v%0d_valid", i), bus.wb_valid_out, 1);
      check($sformatf("v%0d_data", i), bus.wb_wbdata_out, vecs[i].exp_d);
      check($sformatf("v%0d_we", i), bus.wb_reg_we_out, vecs[i].exp_we);
      check($sformatf("v%0d_wnum", i), bus.wb_wnum_out, 3);
      bus.rf_ready_in = 1'b1;
      tick();
      bus.rf_ready_in = 1'b0;
      check($sformatf("v%0d_drain", i), wb_count_out, 0);
      check($sformatf("v%0d_idle_we", i), bus.wb_reg_we_out, 0);
      check($sformatf("v%0d_dbg_data", i), debug_wb_rf_wdata, TRACE ? vecs[i].exp_d : 32'h0);
      check($sformatf("v%0d_dbg_pc", i), debug_wb_pc, TRACE ? 32'h1000 + 32'(i * 4) : 32'h0);
    end
    tick();
    check("dbg_wen_idle", debug_wb_rf_wen, 0);

    // Register 0 still queues and commits, with no byte enables.
    drive(1'b1, 32'h0000_0400, 5'd0, 3'd0, 2'd0, 32'h0, 32'h1111_1111);
    tick();
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    check("r0_valid", bus.wb_valid_out, 1);
    check("r0_we", bus.wb_reg_we_out, 0);
    check("r0_data", bus.wb_wbdata_out, 32'h1111_1111);
    bus.rf_ready_in = 1'b1;
    tick();
    bus.rf_ready_in = 1'b0;
    check("r0_drain", wb_count_out, 0);
    check("r0_dbg_pc", debug_wb_pc, TRACE ? 32'h0000_0400 : 32'h0);
    check("r0_dbg_wen", debug_wb_rf_wen, 0);

    // Backpressure: two entries fill the queue, the third waits and enters on the first commit.
    drive(1'b1, 32'h100, 5'd1, 3'd0, 2'd0, 32'h0, 32'hA1);
    tick();
    check("full_cnt1", wb_count_out, 1);
    drive(1'b1, 32'h104, 5'd2, 3'd0, 2'd0, 32'h0, 32'hB2);
    tick();
    check("full_cnt2", wb_count_out, 2);
    drive(1'b1, 32'h108, 5'd3, 3'd0, 2'd0, 32'h0, 32'hC3);
    #1;
    check("full_allowin", bus.wb_allowin_out, 0);
    tick();
    check("full_hold_cnt", wb_count_out, 2);
    check("full_hold_wnum", bus.wb_wnum_out, 1);
    check("full_hold_data", bus.wb_wbdata_out, 32'hA1);
    bus.rf_ready_in = 1'b1;
    #1;
    check("full_allowin_commit", bus.wb_allowin_out, 1);
    tick();
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    check("full_swap_cnt", wb_count_out, 2);
    check("full_swap_wnum", bus.wb_wnum_out, 2);
    check("full_dbg_wnum_a", debug_wb_rf_wnum, TRACE ? 5'd1 : 5'd0);
    tick();
    check("full_cnt_b", wb_count_out, 1);
    check("full_head_c", bus.wb_wbdata_out, 32'hC3);
    check("full_dbg_pc_b", debug_wb_pc, TRACE ? 32'h104 : 32'h0);
    tick();
    bus.rf_ready_in = 1'b0;
    check("full_empty", wb_count_out, 0);
    check("full_empty_valid", bus.wb_valid_out, 0);
    check("full_dbg_data_c", debug_wb_rf_wdata, TRACE ? 32'hC3 : 32'h0);

    // Flush with a full queue and a same-cycle input: all dropped, no commit.
    drive(1'b1, 32'h200, 5'd4, 3'd0, 2'd0, 32'h0, 32'hD4);
    tick();
    drive(1'b1, 32'h204, 5'd5, 3'd0, 2'd0, 32'h0, 32'hE5);
    tick();
    drive(1'b1, 32'h208, 5'd6, 3'd0, 2'd0, 32'h0, 32'hF6);
    bus.wb_flush_in = 1'b1;
    bus.rf_ready_in = 1'b1;
    #1;
    check("flush_allowin", bus.wb_allowin_out, 0);
    tick();
    bus.wb_flush_in = 1'b0;
    bus.rf_ready_in = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    check("flush_cnt", wb_count_out, 0);
    check("flush_valid", bus.wb_valid_out, 0);
    check("flush_no_commit", debug_wb_rf_wen, 0);
    tick();
    check("flush_dropped", wb_count_out, 0);

    // Accept and commit together at count 1 leaves count unchanged.
    drive(1'b1, 32'h300, 5'd7, 3'd0, 2'd0, 32'h0, 32'h77);
    tick();
    drive(1'b1, 32'h304, 5'd8, 3'd0, 2'd0, 32'h0, 32'h88);
    bus.rf_ready_in = 1'b1;
    tick();
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    check("swap1_cnt", wb_count_out, 1);
    check("swap1_data", bus.wb_wbdata_out, 32'h88);
    check("swap1_wnum", bus.wb_wnum_out, 8);
    tick();
    bus.rf_ready_in = 1'b0;
    check("swap1_drain", wb_count_out, 0);

    // Reset outranks flush and accept mid-operation.
    drive(1'b1, 32'h400, 5'd9, 3'd0, 2'd0, 32'h0, 32'h99);
    tick();
    check("mid_cnt", wb_count_out, 1);
    rst = 1'b1;
    bus.wb_flush_in = 1'b1;
    drive(1'b1, 32'h404, 5'd10, 3'd0, 2'd0, 32'h0, 32'hAA);
    #1;
    check("mid_allowin", bus.wb_allowin_out, 0);
    tick();
    rst = 1'b0;
    bus.wb_flush_in = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 3'd0, 2'd0, 32'h0, 32'h0);
    check("mid_rst_cnt", wb_count_out, 0);
    check("mid_rst_valid", bus.wb_valid_out, 0);
    check("mid_rst_dbg_pc", debug_wb_pc, 0);
    check("mid_rst_dbg_data", debug_wb_rf_wdata, 0);
    tick();
    check("mid_rst_hold", wb_count_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
